// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher between the on-chip instruction RAM
// (read-only use of its second port) and the processor front end.
// Reads are issued against a credit of free FIFO slots, so the FIFO never
// overflows. A redirect flushes the buffer and drops any returning read.
module instr_prefetch_buffer #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ready,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;

    logic              head_valid;
    logic              credit_ok;
    logic              issue;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] issue_addr;

    // Issue decision and handshake qualifiers; a redirect overrides credit
    // because the same edge empties the FIFO, and it squashes push and pop.
    always_comb begin
        head_valid = (count_q != '0);
        credit_ok  = ((count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
        issue      = !reset && enable && (redirect || credit_ok);
        issue_addr = redirect ? redirect_addr : pc_q;
        push       = inflight_q && !redirect;
        pop        = head_valid && instr_ready && !redirect;
    end

    // Next-state for the fetch pointer, in-flight tracking and FIFO.
    always_comb begin
        pc_d        = pc_q;
        tag_d       = tag_q;
        inflight_d  = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_d      = data_q;
        addr_d      = addr_q;
        last_data_d = last_data_q;
        last_addr_d = last_addr_q;

        if (issue) begin
            pc_d       = issue_addr + ADDR_W'(1);
            tag_d      = issue_addr;
            inflight_d = 1'b1;
        end else if (redirect) begin
            pc_d = redirect_addr;
        end

        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = mem_readdata;
                addr_d[wr_ptr_q] = tag_q;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        // Remember what was last shown so the outputs hold while empty.
        if (head_valid) begin
            last_data_d = data_q[rd_ptr_q];
            last_addr_d = addr_q[rd_ptr_q];
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= '0;
            tag_q       <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_data_q <= '0;
            last_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            tag_q       <= tag_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_data_q <= last_data_d;
            last_addr_q <= last_addr_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
        end
    end

    // RAM port is read-only; strobes are tied off except address and select.
    always_comb begin
        mem_address    = issue_addr;
        mem_chipselect = issue;
        mem_clken      = 1'b1;
        mem_write      = 1'b0;
        mem_byteenable = 4'hF;
        mem_writedata  = '0;
        instr_valid    = head_valid;
        instr_data     = head_valid ? data_q[rd_ptr_q] : last_data_q;
        instr_addr     = head_valid ? addr_q[rd_ptr_q] : last_addr_q;
        busy           = head_valid || inflight_q;
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: a RAM model feeds the fetcher, a queue
// model predicts issues and occupancy, and a scoreboard of expected
// (address, word) pairs is checked by an independent output monitor.
module tb_instr_prefetch_buffer;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_addr = '0;
    logic              instr_ready = 1'b0;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata = '0;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_addr;
    logic              busy;

    instr_prefetch_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst), .enable(enable), .redirect(redirect),
        .redirect_addr(redirect_addr), .mem_address(mem_address),
        .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_addr(instr_addr), .instr_ready(instr_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram [2048];

    // One-cycle read latency; unselected cycles return junk.
    always @(posedge clk) mem_readdata <= mem_chipselect ? ram[mem_address] : $urandom;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } exp_t;

    exp_t              sb[$];
    int                m_count = 0;
    bit                m_inflight = 0;
    logic [ADDR_W-1:0] m_pc = '0;
    int                dut_occ = 0;
    bit                prev_cs = 0;

    // Predict this cycle's issue, compare, then advance the queue model.
    task automatic eval_cycle();
        bit                exp_issue;
        logic [ADDR_W-1:0] exp_addr;
        int                occ_next;
        exp_issue = enable && (redirect || (m_count + int'(m_inflight) < DEPTH));
        exp_addr  = redirect ? redirect_addr : m_pc;
        check("chipselect", mem_chipselect, exp_issue);
        if (exp_issue) check("mem_address", mem_address, exp_addr);
        check("instr_valid", instr_valid, m_count != 0);
        check("busy", busy, (m_count != 0) || m_inflight);
        check("const_ports", {mem_clken, mem_write, mem_byteenable, mem_writedata}, {1'b1, 1'b0, 4'hF, 32'h0});

        if (redirect) occ_next = 0;
        else occ_next = dut_occ + int'(prev_cs) - int'(instr_valid && instr_ready);
        check("no_overflow", occ_next <= DEPTH, 1'b1);
        dut_occ = occ_next;
        prev_cs = mem_chipselect;

        if (redirect) begin
            m_count = 0;
            sb.delete();
        end else begin
            if (m_count != 0 && instr_ready) m_count--;
            if (m_inflight) m_count++;
        end
        if (exp_issue) begin
            sb.push_back('{exp_addr, ram[exp_addr]});
            m_pc = exp_addr + 11'd1;
        end else if (redirect) begin
            m_pc = redirect_addr;
        end
        m_inflight = exp_issue;
    endtask

    task automatic step(input bit en, input bit rdy, input bit rd, input logic [ADDR_W-1:0] ra);
        enable        = en;
        instr_ready   = rdy;
        redirect      = rd;
        redirect_addr = ra;
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        #1;
        check("rst_chipselect", mem_chipselect, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        m_count    = 0;
        m_inflight = 0;
        m_pc       = '0;
        dut_occ    = 0;
        prev_cs    = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Fill with ready low until three entries are held and a read is in flight.
    task automatic fill_to_three();
        int n;
        n = 0;
        while (!(m_count == 3 && m_inflight) && n < 10) begin
            step(1, 0, 0, '0);
            n++;
        end
        check("reach_fill3", (m_count == 3) && m_inflight, 1'b1);
    endtask

    // Output monitor: pops the scoreboard on every accepted word.
    logic [ADDR_W-1:0] last_a = '0;
    logic [DATA_W-1:0] last_d = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_a = '0;
                last_d = '0;
            end else if (instr_valid) begin
                if (instr_ready && !redirect) begin
                    check("sb_nonempty", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("instr_addr", instr_addr, e.a);
                        check("instr_data", instr_data, e.d);
                    end
                end
                last_a = instr_addr;
                last_d = instr_data;
            end else begin
                check("hold_addr", instr_addr, last_a);
                check("hold_data", instr_data, last_d);
            end
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = $urandom;

        // Streaming from reset.
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 1, 0, '0);

        // Back-pressure from the start: four issues, then stall, then drain.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0, '0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, '0);

        // Redirect near the top of the address space while streaming.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 0, '0);
        step(1, 1, 1, 11'h7FE);
        for (int i = 0; i < 8; i++) step(1, 1, 0, '0);

        // Redirect coinciding with a pop and a return, three entries held.
        do_reset();
        fill_to_three();
        step(1, 1, 1, 11'h100);
        for (int i = 0; i < 6; i++) step(1, 1, 0, '0);

        // Redirect with enable low only reloads the fetch pointer.
        step(0, 1, 1, 11'h055);
        step(0, 1, 0, '0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, '0);

        // Enable dropping mid-stream lets the in-flight read and FIFO drain.
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, '0);

        // Reset mid-stream with three entries and a read in flight.
        do_reset();
        fill_to_three();
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1, 0, '0);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0,
                 ADDR_W'($urandom));
        end
        for (int i = 0; i < 8; i++) step(0, 1, 0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
